// File: rtl/shift_pkg.sv
// Shared definitions for the shift-unit library: FSM encodings, bit-order constants
// and an elaboration-time clog2 helper.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam logic DIR_LSB = 1'b0;
    localparam logic DIR_MSB = 1'b1;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/piso_shift_serializer_bit_counter.sv
// Bit-position counter for the serializer: clears on accept, advances per transferred
// bit and wraps to zero after the terminal count WIDTH-1.
module bit_counter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/piso_shift_serializer.sv
// Parallel-in serial-out stage with valid/ready on both sides and selectable bit order.
// Optional even-parity trailer bit when SERIALIZER_PARITY_EN is defined.
module piso_shift_serializer
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             msb_first,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_last,
    output logic             busy
);

    localparam int CNT_W = clog2(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shreg_q;
    logic             dir_q;
    logic             tc;
    logic             accept;
    logic             xfer;
    logic             data_xfer;

    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;
    assign data_xfer = xfer && (state_q == SHIFT);

    bit_counter #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_bit_counter (
        .clk  (clk),
        .rst  (rst),
        .clr_i(accept),
        .en_i (data_xfer),
        .tc_o (tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (xfer && tc) begin
`ifdef SERIALIZER_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = IDLE;
`endif
                end
            end
            PARITY: begin
`ifdef SERIALIZER_PARITY_EN
                if (xfer) begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Shift register only moves on data-bit transfers; a stall leaves it untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            dir_q   <= DIR_LSB;
        end else if (accept) begin
            shreg_q <= in_data;
            dir_q   <= msb_first;
        end else if (data_xfer) begin
            if (dir_q == DIR_MSB) begin
                shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
                shreg_q <= {1'b0, shreg_q[WIDTH-1:1]};
            end
        end
    end

`ifdef SERIALIZER_PARITY_EN
    logic par_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else if (accept) begin
            par_q <= ^in_data;
        end
    end
`endif

    always_comb begin
        in_ready  = (state_q == IDLE) && !rst;
        out_valid = 1'b0;
        out_bit   = 1'b0;
        out_last  = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            SHIFT: begin
                out_valid = 1'b1;
                out_bit   = (dir_q == DIR_MSB) ? shreg_q[WIDTH-1] : shreg_q[0];
`ifdef SERIALIZER_PARITY_EN
                out_last  = 1'b0;
`else
                out_last  = tc;
`endif
            end
`ifdef SERIALIZER_PARITY_EN
            PARITY: begin
                out_valid = 1'b1;
                out_bit   = par_q;
                out_last  = 1'b1;
            end
`endif
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_piso_shift_serializer.sv
// Directed testbench for piso_shift_serializer (WIDTH=8); parity trailer checked when
// SERIALIZER_PARITY_EN is defined.
module tb_piso_shift_serializer;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             msb_first;
    logic             out_valid;
    logic             out_ready;
    logic             out_bit;
    logic             out_last;
    logic             busy;

    int n_checks;
    int n_pass;

    piso_shift_serializer #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .msb_first(msb_first),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_bit  (out_bit),
        .out_last (out_last),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a word for one cycle, then scramble in_data/msb_first to prove they are ignored.
    task automatic send_word(input logic [7:0] d, input logic msb);
        in_valid  = 1'b1;
        in_data   = d;
        msb_first = msb;
        check("in_ready_before_accept", in_ready, 1'b1);
        step();
        in_valid  = 1'b0;
        in_data   = ~d;
        msb_first = ~msb;
    endtask

    task automatic recv_word(input logic [7:0] d, input logic msb, input logic par_exp,
                             input int nbits, input int stall_at, input int stall_len);
        logic exp_bit;
        for (int i = 0; i < nbits; i++) begin
            exp_bit = msb ? d[7-i] : d[i];
            if (i == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    check("stall_valid", out_valid, 1'b1);
                    check("stall_bit", out_bit, exp_bit);
                    check("stall_last", out_last, 1'b0);
                    step();
                end
                out_ready = 1'b1;
            end
            check("bit_valid", out_valid, 1'b1);
            check("bit_value", out_bit, exp_bit);
`ifdef SERIALIZER_PARITY_EN
            check("bit_last", out_last, 1'b0);
`else
            check("bit_last", out_last, (i == 7) ? 1'b1 : 1'b0);
`endif
            check("busy_shift", busy, 1'b1);
            check("no_accept_shift", in_ready, 1'b0);
            step();
        end
        if (nbits == 8) begin
`ifdef SERIALIZER_PARITY_EN
            check("par_valid", out_valid, 1'b1);
            check("par_bit", out_bit, par_exp);
            check("par_last", out_last, 1'b1);
            step();
`else
            check("par_unused", {63'd0, par_exp}, {63'd0, par_exp ^ 1'b0});
`endif
            check("end_valid", out_valid, 1'b0);
            check("end_ready", in_ready, 1'b1);
            check("end_busy", busy, 1'b0);
        end
        $display("word %02h msb_first=%0d bits=%0d stall_at=%0d done", d, msb, nbits, stall_at);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        msb_first = 1'b0;
        out_ready = 1'b1;

        repeat (2) step();
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", in_ready, 1'b1);
        check("idle_out_valid", out_valid, 1'b0);
        check("idle_out_bit", out_bit, 1'b0);
        check("idle_out_last", out_last, 1'b0);
        check("idle_busy", busy, 1'b0);
        $display("reset sequence done");

        // A5 MSB-first: 1,0,1,0,0,1,0,1; even parity 0
        send_word(8'hA5, 1'b1);
        recv_word(8'hA5, 1'b1, 1'b0, 8, -1, 0);
        send_word(8'hA5, 1'b0);
        recv_word(8'hA5, 1'b0, 1'b0, 8, -1, 0);
        // 01 LSB-first: 1 then seven 0s; MSB-first: seven 0s then 1; parity 1
        send_word(8'h01, 1'b0);
        recv_word(8'h01, 1'b0, 1'b1, 8, -1, 0);
        send_word(8'h01, 1'b1);
        recv_word(8'h01, 1'b1, 1'b1, 8, -1, 0);
        // C3 MSB-first with 3-cycle stall holding bit index 2 (value 0)
        send_word(8'hC3, 1'b1);
        recv_word(8'hC3, 1'b1, 1'b0, 8, 2, 3);
        // Parity vectors: 07 -> 1, 03 -> 0
        send_word(8'h07, 1'b1);
        recv_word(8'h07, 1'b1, 1'b1, 8, -1, 0);
        send_word(8'h03, 1'b0);
        recv_word(8'h03, 1'b0, 1'b0, 8, -1, 0);

        // Reset after three bits of FF: remaining bits are discarded
        send_word(8'hFF, 1'b1);
        recv_word(8'hFF, 1'b1, 1'b0, 3, -1, 0);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 1'b0);
        step();
        rst = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_in_ready_after", in_ready, 1'b1);
        step();
        check("midrst_still_idle", out_valid, 1'b0);
        send_word(8'h00, 1'b1);
        recv_word(8'h00, 1'b1, 1'b0, 8, -1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
